piano_key_event_tx: RTL and testbench

//  Converts the per-frame tracked-object centroid into debounced piano key events for the UART link.

---
 rtl/piano_key_event_tx.sv | 172 +++++++++++++++++
 tb/tb_piano_key_event_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_key_event_tx.sv
// rtl/piano_key_event_tx.sv - centroid to debounced piano key events, FIFO-buffered onto a paced UART byte stream
module piano_key_event_tx #(
   parameter int N_KEYS        = 8,
   parameter int KEY_X0        = 40,
   parameter int KEY_W         = 70,
   parameter int Y_TOP         = 320,
   parameter int Y_BOT         = 470,
   parameter int STABLE_FRAMES = 3,
   parameter int NOTE_BASE     = 60,
   parameter int MIN_GAP       = 2_000_000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic [9:0] center_x,
   input  logic [9:0] center_y,
   input  logic       sound_enable,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic [7:0] cur_key,
   output logic       overflow
);
   localparam logic [7:0] NONE = 8'hFF;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {EV_IDLE, EV_OFF, EV_ON} ev_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_GAP} tx_state_t;

   logic        vsync_d, sample, accept;
   logic [7:0]  raw, cand, old_key, new_key;
   logic [3:0]  cnt;
   ev_state_t   ev_state, ev_next;
   tx_state_t   tx_state, tx_next;
   logic        push, pop;
   logic [7:0]  push_data, head;
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        full, empty;
   logic [1:0]  wait_cnt;
   logic [31:0] gap_cnt;

   assign sample = vsync && !vsync_d;

   always_comb begin
      raw = NONE;
      if (sound_enable && center_y >= 10'(Y_TOP) && center_y <= 10'(Y_BOT))
         for (int k = 0; k < N_KEYS; k++)
            if ({22'd0, center_x} >= 32'(KEY_X0 + k * KEY_W) &&
                {22'd0, center_x} <= 32'(KEY_X0 + (k + 1) * KEY_W - 1))
               raw = 8'(k);
   end

   // A pending accept waits while the event FSM is still emitting the previous change
   assign accept = (ev_state == EV_IDLE) && (cnt == 4'(STABLE_FRAMES)) && (cand != cur_key);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_d <= 1'b0;
         cand    <= NONE;
         cnt     <= 4'd0;
         cur_key <= NONE;
         old_key <= NONE;
         new_key <= NONE;
      end else begin
         vsync_d <= vsync;
         if (sample) begin
            if (raw == cand) begin
               if (cnt != 4'(STABLE_FRAMES))
                  cnt <= cnt + 4'd1;
            end else begin
               cand <= raw;
               cnt  <= 4'd1;
            end
         end
         if (accept) begin
            cur_key <= cand;
            old_key <= cur_key;
            new_key <= cand;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ev_state <= EV_IDLE;
      else       ev_state <= ev_next;
   end

   always_comb begin
      ev_next = ev_state;
      case (ev_state)
         EV_IDLE: if (accept) ev_next = EV_OFF;
         EV_OFF:  ev_next = EV_ON;
         default: ev_next = EV_IDLE;
      endcase
   end

   always_comb begin
      push      = 1'b0;
      push_data = 8'd0;
      if (ev_state == EV_OFF && old_key != NONE) begin
         push      = 1'b1;
         push_data = 8'h80 | (8'(NOTE_BASE) + old_key);
      end else if (ev_state == EV_ON && new_key != NONE) begin
         push      = 1'b1;
         push_data = 8'(NOTE_BASE) + new_key;
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // When full, a simultaneous pop frees the slot the push writes into
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push && (!full || pop)) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (push && full && !pop)
            overflow <= 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tx_state <= TX_IDLE;
      else       tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE: if (!empty && !tx_busy) tx_next = TX_WAIT;
         TX_WAIT: if (wait_cnt == 2'd2 && !tx_busy) tx_next = (MIN_GAP == 0) ? TX_IDLE : TX_GAP;
         TX_GAP:  if (gap_cnt == 32'(MIN_GAP - 1)) tx_next = TX_IDLE;
         default: tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      pop = (tx_state == TX_IDLE) && !empty && !tx_busy;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data  <= 8'd0;
         tx_start <= 1'b0;
         wait_cnt <= 2'd0;
         gap_cnt  <= 32'd0;
      end else begin
         tx_start <= pop;
         if (pop)
            tx_data <= head;
         if (tx_state != TX_WAIT)
            wait_cnt <= 2'd0;
         else if (wait_cnt != 2'd2)
            wait_cnt <= wait_cnt + 2'd1;
         if (tx_state != TX_GAP)
            gap_cnt <= 32'd0;
         else
            gap_cnt <= gap_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_piano_key_event_tx.sv
// tb/tb_piano_key_event_tx.sv - self-checking bench for piano_key_event_tx
module tb_piano_key_event_tx;
   localparam int MIN_GAP   = 20;
   localparam int SF        = 3;
   localparam int FRAME_CYC = 50;
   localparam int BUSY_CYC  = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vsync = 1'b0;
   logic [9:0] center_x = '0;
   logic [9:0] center_y = '0;
   logic       sound_enable = 1'b1;
   logic       tx_busy = 1'b0;
   logic [7:0] tx_data;
   logic       tx_start;
   logic [7:0] cur_key;
   logic       overflow;

   piano_key_event_tx #(.MIN_GAP(MIN_GAP), .STABLE_FRAMES(SF)) dut (
      .clk(clk), .reset(reset), .vsync(vsync), .center_x(center_x), .center_y(center_y),
      .sound_enable(sound_enable), .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
      .cur_key(cur_key), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_cnt = 0;
   bit hold_busy = 0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int start_t[$];
   logic [7:0] m_cand, m_cur;
   int m_cnt;

   // uart_tx stand-in: busy for a few cycles after each start; also records sent bytes
   always @(negedge clk) begin
      cyc++;
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start === 1'b1) begin
         obs_q.push_back(tx_data);
         start_t.push_back(cyc);
         busy_cnt = BUSY_CYC;
      end
      tx_busy = hold_busy || (busy_cnt > 0);
   end

   function automatic logic [7:0] raw_of(int x, int y, bit en);
      int k;
      if (!en || y < 320 || y > 470 || x < 40) return 8'hFF;
      k = (x - 40) / 70;
      return (k >= 8) ? 8'hFF : 8'(k);
   endfunction

   task automatic model_reset();
      m_cand = 8'hFF; m_cur = 8'hFF; m_cnt = 0;
      exp_q.delete(); obs_q.delete(); start_t.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic frame(int x, int y, bit en);
      logic [7:0] r;
      center_x = 10'(x); center_y = 10'(y); sound_enable = en;
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      r = raw_of(x, y, en);
      if (r == m_cand) begin
         if (m_cnt < SF) m_cnt++;
      end else begin
         m_cand = r; m_cnt = 1;
      end
      if (m_cnt == SF && m_cand != m_cur) begin
         if (m_cur != 8'hFF) exp_q.push_back(8'h80 | (8'd60 + m_cur));
         if (m_cand != 8'hFF) exp_q.push_back(8'd60 + m_cand);
         m_cur = m_cand;
      end
      repeat (FRAME_CYC) @(negedge clk);
      checks++;
      if (cur_key !== m_cur) begin
         errors++;
         $display("FAIL cur_key x=%0d y=%0d en=%0d: got %0h expected %0h", x, y, en, cur_key, m_cur);
      end
   endtask

   task automatic drain();
      int quiet = 0;
      int t = 0;
      while (quiet < 60 && t < 5000) begin
         @(negedge clk);
         if (tx_start === 1'b1) quiet = 0; else quiet++;
         t++;
      end
      checks++;
      if (t >= 5000) begin
         errors++;
         $display("FAIL drain_timeout: got %0d cycles expected < 5000", t);
      end
   endtask

   task automatic compare_bytes(string name);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s byte_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s byte[%0d]: got %0h expected %0h", name, i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete(); start_t.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks += 4;
      if (tx_data !== 8'd0)   begin errors++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
      if (tx_start !== 1'b0)  begin errors++; $display("FAIL reset_tx_start: got %0b expected 0", tx_start); end
      if (cur_key !== 8'hFF)  begin errors++; $display("FAIL reset_cur_key: got %0h expected ff", cur_key); end
      if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
   endtask

   task automatic test_single_key();
      repeat (2) frame(120, 400, 1);
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL early_bytes: got %0d expected 0", obs_q.size()); end
      frame(120, 400, 1);
      drain();
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== 8'd61) begin
         errors++;
         $display("FAIL single_key_byte: got %0d bytes first %0h expected 1 byte 3d", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'h00);
      end
      compare_bytes("single_key");
   endtask

   task automatic test_change();
      repeat (3) frame(330, 400, 1);
      drain();
      checks++;
      if (obs_q.size() != 2 || obs_q[0] !== 8'hBD || obs_q[1] !== 8'd64) begin
         errors++;
         $display("FAIL change_bytes: got %0d bytes expected bd,40", obs_q.size());
      end
      if (start_t.size() == 2) begin
         checks++;
         if (start_t[1] - start_t[0] <= MIN_GAP) begin
            errors++;
            $display("FAIL change_gap: got %0d cycles expected > %0d", start_t[1] - start_t[0], MIN_GAP);
         end
      end
      compare_bytes("change");
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 200 : 280, 400, 1);
      drain();
      checks++;
      if (cur_key !== 8'd4) begin errors++; $display("FAIL alternate_key: got %0h expected 4", cur_key); end
      compare_bytes("alternate");
   endtask

   task automatic test_sound_off();
      repeat (3) frame(425, 400, 1);
      drain();
      compare_bytes("key5");
      repeat (3) frame(425, 400, 0);
      drain();
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== 8'hC1) begin
         errors++;
         $display("FAIL sound_off_byte: got %0d bytes expected 1 byte c1", obs_q.size());
      end
      compare_bytes("sound_off");
   endtask

   task automatic test_random();
      for (int s = 0; s < 30; s++) begin
         int k, x, y, hold;
         bit en;
         k = $urandom_range(0, 9);
         x = (k < 8) ? 40 + k * 70 + $urandom_range(0, 69) : $urandom_range(0, 700);
         y = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(320, 470);
         en = ($urandom_range(0, 7) != 0);
         hold = $urandom_range(1, 4);
         for (int h = 0; h < hold; h++) frame(x, y, en);
      end
      drain();
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL random_overflow: got %0b expected 0", overflow); end
      compare_bytes("random");
   endtask

   task automatic test_boundaries();
      int px[6] = '{40, 39, 599, 600, 40, 100};
      int py[6] = '{320, 400, 470, 400, 319, 471};
      logic [7:0] ek[6] = '{8'd0, 8'hFF, 8'd7, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 6; i++) begin
         repeat (3) frame(px[i], py[i], 1);
         checks++;
         if (cur_key !== ek[i]) begin
            errors++;
            $display("FAIL boundary x=%0d y=%0d: got %0h expected %0h", px[i], py[i], cur_key, ek[i]);
         end
      end
      drain();
      compare_bytes("boundaries");
   endtask

   task automatic test_overflow();
      do_reset();
      hold_busy = 1;
      repeat (3) @(negedge clk);
      for (int k = 1; k <= 6; k++) repeat (3) frame(40 + k * 70 + 10, 400, 1);
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %0b expected 1", overflow); end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL overflow_sent_while_busy: got %0d expected 0", obs_q.size()); end
      while (exp_q.size() > 4) void'(exp_q.pop_back());
      hold_busy = 0;
      drain();
      compare_bytes("overflow");
   endtask

   task automatic test_reset_gap();
      int t = 0;
      do_reset();
      repeat (3) frame(120, 400, 1);
      while (start_t.size() == 0 && t < 500) begin @(negedge clk); t++; end
      checks++;
      if (t >= 500) begin errors++; $display("FAIL reset_gap_no_start: got timeout expected tx_start"); end
      repeat (12) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks += 4;
      if (tx_data !== 8'd0)  begin errors++; $display("FAIL gap_reset_tx_data: got %0h expected 0", tx_data); end
      if (tx_start !== 1'b0) begin errors++; $display("FAIL gap_reset_tx_start: got %0b expected 0", tx_start); end
      if (cur_key !== 8'hFF) begin errors++; $display("FAIL gap_reset_cur_key: got %0h expected ff", cur_key); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL gap_reset_overflow: got %0b expected 0", overflow); end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_key();
      test_change();
      test_alternate();
      test_sound_off();
      test_random();
      test_boundaries();
      test_overflow();
      test_reset_gap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
